// File: rtl/hwpe_stream_sink_linear_pkg.sv
// Shared types and constants for the linear stream sink (stream -> TCDM writer).
package hwpe_stream_sink_linear_pkg;

  localparam int unsigned TCDM_WORD_BYTES = 4;
  localparam int unsigned SINK_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWorking = 2'd1,
    StDone    = 2'd2
  } state_sourcesink_t;

  typedef struct packed {
    logic                      req_start;
    logic [31:0]               base_addr;
    logic [SINK_CNT_WIDTH-1:0] trans_size;
  } ctrl_sink_linear_t;

  typedef struct packed {
    logic              ready_start;
    logic              done;
    state_sourcesink_t state;
    logic [7:0]        outstanding;
  } flags_sink_linear_t;

  // Population count of up to 32 request/response strobes.
  function automatic logic [7:0] count_ones(input logic [31:0] vec);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {7'd0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_grant_hold.sv
// Per-port grant hold for multi-port TCDM masters: remembers ports already
// granted for the current beat so they are not requested again, and reports
// when every port has been granted (now or earlier).
module hwpe_stream_tcdm_grant_hold #(
  parameter int unsigned NB_PORTS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [NB_PORTS-1:0] i_gnt,
  input  logic                i_handshake,
  output logic [NB_PORTS-1:0] o_hold,
  output logic                o_all_gnt
);

  logic [NB_PORTS-1:0] r_hold;

  // A port counts as served if granted this cycle or held from an earlier one.
  always_comb begin
    o_all_gnt = &(i_gnt | r_hold);
    o_hold    = r_hold;
  end

  // Capture early grants; drop all holds once the beat completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold <= '0;
    end else if (clear_i || i_handshake) begin
      r_hold <= '0;
    end else begin
      r_hold <= r_hold | (i_gnt & {NB_PORTS{~o_all_gnt}});
    end
  end

endmodule

// File: rtl/hwpe_stream_sink_linear.sv
// Linear stream sink: splits each stream beat into 32-bit words and writes
// them to consecutive TCDM addresses, counting beats up to trans_size.
// Optional macro HWPE_STREAM_SINK_WAIT_RVALID_EN: keep DONE until every
// granted write has been acknowledged by r_valid.
module hwpe_stream_sink_linear
  import hwpe_stream_sink_linear_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
  parameter int unsigned CNT_WIDTH     = SINK_CNT_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  // TCDM master ports
  output logic [NB_TCDM_PORTS-1:0]            tcdm_req_o,
  output logic [NB_TCDM_PORTS-1:0][31:0]      tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]            tcdm_wen_o,
  output logic [NB_TCDM_PORTS-1:0][3:0]       tcdm_be_o,
  output logic [NB_TCDM_PORTS-1:0][31:0]      tcdm_data_o,
  input  logic [NB_TCDM_PORTS-1:0]            tcdm_gnt_i,
  input  logic [NB_TCDM_PORTS-1:0]            tcdm_r_valid_i,
  input  logic [NB_TCDM_PORTS-1:0][31:0]      tcdm_r_data_i,
  // Input stream
  input  logic                                stream_valid_i,
  output logic                                stream_ready_o,
  input  logic [DATA_WIDTH-1:0]               stream_data_i,
  input  logic [DATA_WIDTH/8-1:0]             stream_strb_i,
  // Control / status
  input  ctrl_sink_linear_t                   ctrl_i,
  output flags_sink_linear_t                  flags_o
);

  localparam logic [31:0] BeatBytes = 32'(TCDM_WORD_BYTES * NB_TCDM_PORTS);

  state_sourcesink_t          r_state;
  logic [CNT_WIDTH-1:0]       r_cnt;
  logic [CNT_WIDTH-1:0]       r_size;
  logic [31:0]                r_addr;
  logic                       r_done;
  logic [7:0]                 w_outstanding;
  logic                       w_active;
  logic                       w_all_gnt;
  logic                       w_hs;
  logic [NB_TCDM_PORTS-1:0]   w_gnt;
  logic [NB_TCDM_PORTS-1:0]   w_hold;

  // A zero-length transfer never requests; it just passes through WORKING.
  assign w_active = (r_state == StWorking) && (r_size != '0);

  // Fan the current beat out over the ports, skipping already-granted ones.
  always_comb begin
    for (int unsigned ii = 0; ii < NB_TCDM_PORTS; ii++) begin
      tcdm_req_o[ii]  = w_active & stream_valid_i & ~w_hold[ii];
      tcdm_add_o[ii]  = r_addr + 32'(TCDM_WORD_BYTES * ii);
      tcdm_wen_o[ii]  = 1'b0;
      tcdm_be_o[ii]   = stream_strb_i[4*ii +: 4];
      tcdm_data_o[ii] = stream_data_i[32*ii +: 32];
    end
  end

  // Only grants for live requests count towards completing a beat.
  assign w_gnt          = tcdm_gnt_i & tcdm_req_o;
  assign stream_ready_o = w_active & w_all_gnt;
  assign w_hs           = stream_valid_i & stream_ready_o;

  hwpe_stream_tcdm_grant_hold #(
    .NB_PORTS (NB_TCDM_PORTS)
  ) u_grant_hold (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .i_gnt       (w_gnt),
    .i_handshake (w_hs),
    .o_hold      (w_hold),
    .o_all_gnt   (w_all_gnt)
  );

  // Transfer sequencing: address/beat counters and the registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_size  <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_size  <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ctrl_i.req_start) begin
            r_addr  <= ctrl_i.base_addr;
            r_size  <= CNT_WIDTH'(ctrl_i.trans_size);
            r_cnt   <= '0;
            r_state <= StWorking;
          end
        end
        StWorking: begin
          if (r_size == '0) begin
            r_state <= StDone;
          end else if (w_hs) begin
            r_cnt  <= r_cnt + 1'b1;
            r_addr <= r_addr + BeatBytes;
            if (r_cnt == r_size - 1'b1) begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
`ifdef HWPE_STREAM_SINK_WAIT_RVALID_EN
          if (w_outstanding == '0) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
`else
          r_state <= StIdle;
          r_done  <= 1'b1;
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef HWPE_STREAM_SINK_WAIT_RVALID_EN
  logic [7:0] r_outstanding;
  logic       w_unused_rsp;

  // Writes in flight: grants issued minus responses returned, net per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (clear_i) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + count_ones(32'(w_gnt))
                       - count_ones(32'(tcdm_r_valid_i));
    end
  end

  assign w_outstanding = r_outstanding;
  assign w_unused_rsp  = ^tcdm_r_data_i;
`else
  logic w_unused_rsp;

  assign w_outstanding = '0;
  assign w_unused_rsp  = ^{tcdm_r_data_i, tcdm_r_valid_i};
`endif

  // Status towards the controller.
  always_comb begin
    flags_o.ready_start = (r_state == StIdle);
    flags_o.done        = r_done;
    flags_o.state       = r_state;
    flags_o.outstanding = w_outstanding;
  end

endmodule

// File: doc/hwpe_stream_sink_linear.md
Name: hwpe_stream_sink_linear

Overview:
Stream-to-TCDM write engine, the writer counterpart of the streamer source.
- Accepts one DATA_WIDTH-bit HWPE stream.
- Splits each beat into NB_TCDM_PORTS 32-bit words.
- Writes them to consecutive TCDM addresses using a built-in linear address counter.
- Sits between an engine's output stream and the TCDM interconnect. Programmed by the HWPE controller with base address and beat count; reports a done pulse.

Parameters:
- DATA_WIDTH, 32, stream data width; multiple of 32.
- NB_TCDM_PORTS, DATA_WIDTH/32, number of 32-bit TCDM master ports.
- CNT_WIDTH, 16, width of the beat counter and trans_size.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- tcdm  master  NB_TCDM_PORTS x hwpe_stream_intf_tcdm  write ports.
- stream  sink  hwpe_stream_intf_stream (DATA_WIDTH)  input data stream.
- ctrl_i  in  ctrl_sink_linear_t  fields: req_start, base_addr[31:0], trans_size[CNT_WIDTH-1:0].
- flags_o  out  flags_sink_linear_t  fields: ready_start, done, state, outstanding[7:0].

Behaviour:
- Reset/clear values: state=IDLE, beat counter 0, latched address 0, per-port grant-hold 0, flags_o.done 0.
  - All tcdm.req 0, stream.ready 0, outstanding 0.
- State machine: IDLE, WORKING, DONE.
- IDLE:
  - ready_start=1.
  - On req_start: latch base_addr into addr_q and trans_size into size_q, clear cnt, go to WORKING.
  - stream.ready=0 in IDLE.
- WORKING, per port ii:
  - tcdm[ii].req = stream.valid & ~hs_q[ii].
  - add = addr_q + 4*ii; wen=0 (write).
  - be = stream.strb[4*ii+3:4*ii]; data = stream.data[32*ii+31:32*ii].
- Per-port grant hold:
  - hs_q[ii] is set when tcdm[ii].gnt arrives while some other port is still ungranted.
  - all_gnt = AND over ii of (gnt[ii] | hs_q[ii]).
  - stream.ready = all_gnt. Zero-latency acceptance: ready may be combinationally high in the same cycle as gnt.
  - On the handshake (valid & ready), all hs_q clear.
  - No port is ever re-requested for a beat it already wrote.
- On each handshake:
  - cnt += 1 and addr_q += 4*NB_TCDM_PORTS, 32-bit wrap-around, no error.
  - If the handshake happens with cnt == size_q-1, go to DONE.
- trans_size==0: WORKING issues no requests; transition to DONE on the first WORKING cycle.
- stream.valid low in WORKING: no requests. hs_q holds; partial grants are never replayed.
- DONE: stream.ready=0, no requests. Go to IDLE per Optional Feature.
- Done flag: flags_o.done is registered and high exactly one cycle, the first IDLE cycle after DONE.
- req_start while not in IDLE is ignored.
- Reset or clear mid-transfer: immediate return to IDLE, no done pulse. Pending hs_q and the counter are dropped.
- flags_o.state = current state.
- tcdm.r_valid and r_data are ignored, except as given under Optional Feature.

Optional Feature:
- Macro: HWPE_STREAM_SINK_WAIT_RVALID_EN.
- Defined:
  - An 8-bit outstanding counter increments by the number of tcdm gnt in a cycle and decrements by the number of r_valid in a cycle (net of both in the same cycle).
  - DONE stays until outstanding==0, then goes to IDLE.
  - flags_o.outstanding reflects the counter.
- Undefined:
  - DONE lasts exactly one cycle.
  - flags_o.outstanding tied to 0; r_valid fully ignored.

Decomposition:
- hwpe_stream_package gains:
  - ctrl_sink_linear_t and flags_sink_linear_t.
  - state enum IDLE/WORKING/DONE; reuse state_sourcesink_t if it matches.
  - Constant TCDM_WORD_BYTES=4.
- One sub-module is natural: hwpe_stream_tcdm_grant_hold, holding per-port hs_q and producing all_gnt. It is reusable by other multi-port TCDM masters.

Test Plan:
- Basic burst: DATA_WIDTH=64, base=0x1000, size=4, always-grant, valid always high.
  - Expect port0 writes at 0x1000, 0x1008, 0x1010, 0x1018; port1 at +4.
  - One beat per cycle; done high exactly 1 cycle in the first IDLE cycle, after 4 handshakes and 1 DONE cycle.
- Skewed grants: port1 gnt delayed 3 cycles on beat 2.
  - Expect port0 req low after its gnt; stream.ready high only in the cycle of port1 gnt.
  - Exactly 8 total writes, no duplicates.
- Stream bubbles and strobes: valid toggled 1-0-1, strb=0x0F on beat 1.
  - Expect no req while valid low; port1 be=0 and port0 be=0xF on beat 1.
  - Addresses unchanged across bubbles.
- Edge sizes: size=0 -> no tcdm req, done 2 cycles after start. size=1 -> single write, then done.
  - base=0xFFFFFFF8, size=2 -> second beat at 0x00000000.
- Abort: assert rst_i asynchronously, then separately clear_i, mid-burst after 2 of 5 beats.
  - Expect req=0 and state IDLE, no done pulse.
  - A new start with base=0x2000 writes from 0x2000.
- With HWPE_STREAM_SINK_WAIT_RVALID_EN: r_valid lags gnt by 5 cycles, size=3, 2 ports.
  - Expect outstanding peaks at 6 and stays in DONE until 0; done pulses on the first IDLE cycle after.
